// File: rtl/fp_align_pipe.sv
// Two-stage exponent-compare / significand-alignment pipeline for the FP adder.
// Optional macro ALIGN_STATS_EN adds saturating output-transfer and sticky counters.
module fp_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [MAN_W-1:0] man_a,
  input  logic [MAN_W-1:0] man_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_sign_big,
  output logic             out_sign_small,
  output logic [MAN_W:0]   out_man_big,
  output logic [MAN_W:0]   out_man_small,
  output logic             out_guard,
  output logic             out_round,
  output logic             out_sticky,
  output logic             out_swap,
  output logic             out_special
`ifdef ALIGN_STATS_EN
  ,
  output logic [15:0]      stat_xfers,
  output logic [15:0]      stat_sticky
`endif
);

  localparam int SIG_W = MAN_W + 1;
  localparam int EXT_W = MAN_W + 3;

  // Stage 1 combinational: effective exponents, magnitude ordering, difference.
  logic             w_hid_a, w_hid_b, w_swap, w_special;
  logic [EXP_W-1:0] w_eff_a, w_eff_b, w_eff_big, w_eff_small, w_diff;
  logic [SIG_W-1:0] w_sig_a, w_sig_b;

  assign w_hid_a     = |exp_a;
  assign w_hid_b     = |exp_b;
  assign w_eff_a     = w_hid_a ? exp_a : EXP_W'(1);
  assign w_eff_b     = w_hid_b ? exp_b : EXP_W'(1);
  assign w_sig_a     = {w_hid_a, man_a};
  assign w_sig_b     = {w_hid_b, man_b};
  // Full significand (with hidden bit) breaks exponent ties, so a denormal
  // never outranks a normal that shares effective exponent 1.
  assign w_swap      = {w_eff_b, w_sig_b} > {w_eff_a, w_sig_a};
  assign w_special   = (&exp_a) | (&exp_b);
  assign w_eff_big   = w_swap ? w_eff_b : w_eff_a;
  assign w_eff_small = w_swap ? w_eff_a : w_eff_b;
  assign w_diff      = w_eff_big - w_eff_small;

  logic             r_s1_valid, r_s1_sign_big, r_s1_sign_small, r_s1_swap, r_s1_special;
  logic [EXP_W-1:0] r_s1_exp, r_s1_diff;
  logic [SIG_W-1:0] r_s1_sig_big, r_s1_sig_small;

  logic w_s2_adv;
  logic r_s2_valid;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;

  // NOTE: data registers are reset as well because the outputs must read 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid      <= 1'b0;
      r_s1_sign_big   <= 1'b0;
      r_s1_sign_small <= 1'b0;
      r_s1_swap       <= 1'b0;
      r_s1_special    <= 1'b0;
      r_s1_exp        <= '0;
      r_s1_diff       <= '0;
      r_s1_sig_big    <= '0;
      r_s1_sig_small  <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign_big   <= w_swap ? sign_b : sign_a;
        r_s1_sign_small <= w_swap ? sign_a : sign_b;
        r_s1_swap       <= w_swap;
        r_s1_special    <= w_special;
        r_s1_exp        <= w_special ? {EXP_W{1'b1}} : w_eff_big;
        r_s1_diff       <= w_diff;
        r_s1_sig_big    <= w_swap ? w_sig_b : w_sig_a;
        r_s1_sig_small  <= w_swap ? w_sig_a : w_sig_b;
      end
    end
  end

  // Stage 2 combinational: shifting by >= EXT_W empties the shifted word and
  // turns the lost-bit mask all-ones, so saturation needs no separate branch.
  logic [EXT_W-1:0] w_ext, w_shifted, w_lost_mask;
  logic             w_sticky;

  assign w_ext       = {r_s1_sig_small, 2'b00};
  assign w_shifted   = w_ext >> r_s1_diff;
  assign w_lost_mask = ~({EXT_W{1'b1}} << r_s1_diff);
  assign w_sticky    = |(w_ext & w_lost_mask);

  logic             r_out_sign_big, r_out_sign_small, r_out_guard, r_out_round;
  logic             r_out_sticky, r_out_swap, r_out_special;
  logic [EXP_W-1:0] r_out_exp;
  logic [SIG_W-1:0] r_out_man_big, r_out_man_small;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid       <= 1'b0;
      r_out_sign_big   <= 1'b0;
      r_out_sign_small <= 1'b0;
      r_out_guard      <= 1'b0;
      r_out_round      <= 1'b0;
      r_out_sticky     <= 1'b0;
      r_out_swap       <= 1'b0;
      r_out_special    <= 1'b0;
      r_out_exp        <= '0;
      r_out_man_big    <= '0;
      r_out_man_small  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_sign_big   <= r_s1_sign_big;
        r_out_sign_small <= r_s1_sign_small;
        r_out_guard      <= w_shifted[1];
        r_out_round      <= w_shifted[0];
        r_out_sticky     <= w_sticky;
        r_out_swap       <= r_s1_swap;
        r_out_special    <= r_s1_special;
        r_out_exp        <= r_s1_exp;
        r_out_man_big    <= r_s1_sig_big;
        r_out_man_small  <= w_shifted[EXT_W-1:2];
      end
    end
  end

  assign out_valid      = r_s2_valid;
  assign out_exp        = r_out_exp;
  assign out_sign_big   = r_out_sign_big;
  assign out_sign_small = r_out_sign_small;
  assign out_man_big    = r_out_man_big;
  assign out_man_small  = r_out_man_small;
  assign out_guard      = r_out_guard;
  assign out_round      = r_out_round;
  assign out_sticky     = r_out_sticky;
  assign out_swap       = r_out_swap;
  assign out_special    = r_out_special;

`ifdef ALIGN_STATS_EN
  logic [15:0] r_stat_xfers, r_stat_sticky;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_xfers  <= '0;
      r_stat_sticky <= '0;
    end else if (r_s2_valid && out_ready) begin
      if (r_stat_xfers != 16'hFFFF) r_stat_xfers <= r_stat_xfers + 16'd1;
      if (r_out_sticky && (r_stat_sticky != 16'hFFFF)) r_stat_sticky <= r_stat_sticky + 16'd1;
    end
  end

  assign stat_xfers  = r_stat_xfers;
  assign stat_sticky = r_stat_sticky;
`endif

endmodule

// File: tb/tb_fp_align_pipe.sv
// Self-checking bench for fp_align_pipe: directed vectors, randomized streaming
// against an arithmetic reference model, backpressure and mid-flight reset.
module tb_fp_align_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, out_valid, out_ready;
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b, out_exp;
  logic [MAN_W-1:0] man_a, man_b;
  logic             out_sign_big, out_sign_small, out_guard, out_round, out_sticky;
  logic             out_swap, out_special;
  logic [MAN_W:0]   out_man_big, out_man_small;
`ifdef ALIGN_STATS_EN
  logic [15:0]      stat_xfers, stat_sticky;
`endif

  always #5 clk = ~clk;

  fp_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
    .man_a(man_a), .man_b(man_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_sign_big(out_sign_big), .out_sign_small(out_sign_small),
    .out_man_big(out_man_big), .out_man_small(out_man_small),
    .out_guard(out_guard), .out_round(out_round), .out_sticky(out_sticky),
`ifdef ALIGN_STATS_EN
    .stat_xfers(stat_xfers), .stat_sticky(stat_sticky),
`endif
    .out_swap(out_swap), .out_special(out_special)
  );

  typedef struct packed {
    logic [7:0]  e;
    logic        sb;
    logic        ss;
    logic [23:0] mb;
    logic [23:0] ms;
    logic        g;
    logic        r;
    logic        s;
    logic        sw;
    logic        sp;
  } res_t;

  typedef struct {
    logic        sa;
    logic [7:0]  ea;
    logic [22:0] ma;
    logic        sb;
    logic [7:0]  eb;
    logic [22:0] mb;
    res_t        r;
  } dvec_t;

  res_t exp_q[$];
  res_t act_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_xfer = 0;
  int   n_sticky = 0;

  // Reference: compare real magnitudes, then shift with integer divide/modulo.
  function automatic res_t model(logic sa, logic [7:0] ea, logic [22:0] ma,
                                 logic sb, logic [7:0] eb, logic [22:0] mb);
    longint sig_a, sig_b, eff_a, eff_b, sig_big, sig_small, eff_big, eff_small;
    longint d, ext, shifted;
    bit     swap, sticky;
    res_t   r;
    sig_a = (ea != 0) ? (longint'(1) << 23) + longint'(ma) : longint'(ma);
    sig_b = (eb != 0) ? (longint'(1) << 23) + longint'(mb) : longint'(mb);
    eff_a = (ea == 0) ? 1 : longint'(ea);
    eff_b = (eb == 0) ? 1 : longint'(eb);
    swap  = (eff_b * (longint'(1) << 24) + sig_b) > (eff_a * (longint'(1) << 24) + sig_a);
    sig_big   = swap ? sig_b : sig_a;
    sig_small = swap ? sig_a : sig_b;
    eff_big   = swap ? eff_b : eff_a;
    eff_small = swap ? eff_a : eff_b;
    d   = eff_big - eff_small;
    ext = sig_small * 4;
    if (d >= 26) begin
      shifted = 0;
      sticky  = (ext != 0);
    end else begin
      shifted = ext / (longint'(1) << d);
      sticky  = (ext % (longint'(1) << d)) != 0;
    end
    r.e  = (ea == 8'hFF || eb == 8'hFF) ? 8'hFF : 8'(eff_big);
    r.sb = swap ? sb : sa;
    r.ss = swap ? sa : sb;
    r.mb = 24'(sig_big);
    r.ms = 24'(shifted / 4);
    r.g  = ((shifted / 2) % 2) != 0;
    r.r  = (shifted % 2) != 0;
    r.s  = sticky;
    r.sw = swap;
    r.sp = (ea == 8'hFF || eb == 8'hFF);
    return r;
  endfunction

  function automatic res_t cap();
    res_t r;
    r.e  = out_exp;       r.sb = out_sign_big;  r.ss = out_sign_small;
    r.mb = out_man_big;   r.ms = out_man_small; r.g  = out_guard;
    r.r  = out_round;     r.s  = out_sticky;    r.sw = out_swap;
    r.sp = out_special;
    return r;
  endfunction

  // One clock: record what transfers at the coming edge, then return just after it.
  task automatic step();
    @(negedge clk);
    if (in_valid && in_ready) exp_q.push_back(model(sign_a, exp_a, man_a, sign_b, exp_b, man_b));
    if (out_valid && out_ready) begin
      act_q.push_back(cap());
      n_xfer++;
      if (out_sticky) n_sticky++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    sign_a = 1'($urandom);
    sign_b = 1'($urandom);
    case ($urandom_range(0, 5))
      0:       exp_a = 8'h00;
      1:       exp_a = 8'hFF;
      default: exp_a = 8'($urandom);
    endcase
    if ($urandom_range(0, 3) == 0) exp_b = 8'($urandom);
    else exp_b = exp_a + 8'($urandom_range(0, 30)) - 8'd15;
    man_a = 23'($urandom);
    man_b = 23'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sign_a = 0; sign_b = 0; exp_a = 0; exp_b = 0; man_a = 0; man_b = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (cap() !== res_t'(0)) begin errors++; $display("FAIL reset_data: got %h expected 0", cap()); end
  endtask

  task automatic test_directed();
    dvec_t dq[$];
    res_t  got;
    //                sa  ea      ma          sb  eb      mb            e       sb ss mb          ms          g  r  s  sw sp
    dq.push_back('{1'b1, 8'd127, 23'h000000, 1'b0, 8'd127, 23'h400000, '{8'd127, 1'b0, 1'b1, 24'hC00000, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}});
    dq.push_back('{1'b0, 8'd130, 23'h000000, 1'b1, 8'd127, 23'h000001, '{8'd130, 1'b0, 1'b1, 24'h800000, 24'h100000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}});
    dq.push_back('{1'b0, 8'd170, 23'h000000, 1'b0, 8'd130, 23'h123456, '{8'd170, 1'b0, 1'b0, 24'h800000, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}});
    dq.push_back('{1'b0, 8'd170, 23'h000000, 1'b0, 8'd130, 23'h000000, '{8'd170, 1'b0, 1'b0, 24'h800000, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}});
    dq.push_back('{1'b1, 8'd0,   23'h000004, 1'b0, 8'd1,   23'h000000, '{8'd1,   1'b0, 1'b1, 24'h800000, 24'h000004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}});
    dq.push_back('{1'b0, 8'd0,   23'h000000, 1'b1, 8'd0,   23'h000000, '{8'd1,   1'b0, 1'b1, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}});
    dq.push_back('{1'b0, 8'd255, 23'h000000, 1'b0, 8'd127, 23'h000000, '{8'd255, 1'b0, 1'b0, 24'h800000, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}});
    dq.push_back('{1'b0, 8'd151, 23'h000000, 1'b0, 8'd127, 23'h000000, '{8'd151, 1'b0, 1'b0, 24'h800000, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}});
    dq.push_back('{1'b0, 8'd152, 23'h000000, 1'b0, 8'd127, 23'h000001, '{8'd152, 1'b0, 1'b0, 24'h800000, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}});
    dq.push_back('{1'b0, 8'd153, 23'h000000, 1'b0, 8'd127, 23'h000000, '{8'd153, 1'b0, 1'b0, 24'h800000, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}});
    dq.push_back('{1'b0, 8'd127, 23'h7FFFFF, 1'b1, 8'd127, 23'h7FFFFF, '{8'd127, 1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}});
    dq.push_back('{1'b0, 8'd127, 23'h000001, 1'b1, 8'd128, 23'h000000, '{8'd128, 1'b1, 1'b0, 24'h800000, 24'h400000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}});
    out_ready = 1'b1;
    foreach (dq[i]) begin
      sign_a = dq[i].sa; exp_a = dq[i].ea; man_a = dq[i].ma;
      sign_b = dq[i].sb; exp_b = dq[i].eb; man_b = dq[i].mb;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid: got %b expected 0", i, out_valid); end
      step();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_latency: got out_valid=%b expected 1", i, out_valid); end
      got = cap();
      checks++;
      if (got !== dq[i].r) begin errors++; $display("FAIL dir%0d_data: got %h expected %h", i, got, dq[i].r); end
      step();
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_random();
    res_t a, e;
    exp_q.delete(); act_q.delete();
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      if (in_valid) rand_inputs();
      out_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 10 && act_q.size() < exp_q.size(); k++) step();
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count: got %0d expected %0d", act_q.size(), exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL random_data: got %h expected %h", a, e); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_back_to_back();
    res_t a, e;
    exp_q.delete(); act_q.delete();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rand_inputs();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready); end
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10 && act_q.size() < 20; k++) step();
    checks++;
    if (act_q.size() != 20 || exp_q.size() != 20) begin
      errors++; $display("FAIL b2b_count: got %0d out %0d in expected 20", act_q.size(), exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL b2b_data: got %h expected %h", a, e); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_backpressure();
    dvec_t v[4];
    res_t  held, a, e;
    int    idx;
    exp_q.delete(); act_q.delete();
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      v[i].sa = sign_a; v[i].ea = exp_a; v[i].ma = man_a;
      v[i].sb = sign_b; v[i].eb = exp_b; v[i].mb = man_b;
    end
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 4; c++) begin
      sign_a = v[idx].sa; exp_a = v[idx].ea; man_a = v[idx].ma;
      sign_b = v[idx].sb; exp_b = v[idx].eb; man_b = v[idx].mb;
      in_valid = 1'b1;
      step();
      idx = exp_q.size();
    end
    checks++;
    if (exp_q.size() != 2) begin errors++; $display("FAIL bp_accepted: got %0d expected 2", exp_q.size()); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
    held = cap();
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (cap() !== held) begin errors++; $display("FAIL bp_hold: got %h expected %h", cap(), held); end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && !(act_q.size() == 4 && idx == 4); c++) begin
      if (idx < 4) begin
        sign_a = v[idx].sa; exp_a = v[idx].ea; man_a = v[idx].ma;
        sign_b = v[idx].sb; exp_b = v[idx].eb; man_b = v[idx].mb;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      idx = exp_q.size();
    end
    in_valid = 1'b0;
    checks++;
    if (act_q.size() != 4) begin errors++; $display("FAIL bp_drain_count: got %0d expected 4", act_q.size()); end
    for (int i = 0; i < 4 && act_q.size() > 0; i++) begin
      a = act_q.pop_front();
      e = model(v[i].sa, v[i].ea, v[i].ma, v[i].sb, v[i].eb, v[i].mb);
      checks++;
      if (a !== e) begin errors++; $display("FAIL bp_order%0d: got %h expected %h", i, a, e); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_reset_midflight();
    exp_q.delete(); act_q.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    rand_inputs(); step();
    rand_inputs(); step();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_full: got valid=%b ready=%b expected 1/0", out_valid, in_ready);
    end
`ifdef ALIGN_STATS_EN
    checks++;
    if (stat_xfers !== 16'(n_xfer) || stat_sticky !== 16'(n_sticky)) begin
      errors++; $display("FAIL stats_count: got %0d/%0d expected %0d/%0d", stat_xfers, stat_sticky, n_xfer, n_sticky);
    end
`endif
    reset = 1'b1; out_ready = 1'b1; rand_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (cap() !== res_t'(0)) begin errors++; $display("FAIL midrst_data: got %h expected 0", cap()); end
`ifdef ALIGN_STATS_EN
    checks++;
    if (stat_xfers !== 16'd0 || stat_sticky !== 16'd0) begin
      errors++; $display("FAIL stats_reset: got %0d/%0d expected 0/0", stat_xfers, stat_sticky);
    end
`endif
    n_xfer = 0; n_sticky = 0;
    exp_q.delete(); act_q.delete();
    repeat (5) step();
    checks++;
    if (act_q.size() != 0) begin errors++; $display("FAIL midrst_stale: got %0d outputs expected 0", act_q.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
